func_gen_dds: RTL and testbench
===============================

Name: func_gen_dds

Overview:
Parametrised direct-digital-synthesis (DDS) waveform generator. It replaces the counter-per-sample address stepping with an ACC_W-bit phase accumulator, which gives fractional frequency resolution.
- Produces sine from an external LUT, plus computed triangle, sawtooth, square and PWM waveforms.
- All modes have equal, fixed pipeline latency.
- New configuration is taken through a valid/ready handshake and applied glitch-free at the phase wrap.
- Sits between the AXI/register front end (config source) and the DAC/PWM output stage.

Parameters:
ACC_W, 32, phase accumulator and frequency word width (>= OUT_W+2)
OUT_W, 8, output sample width and LUT data width
LUT_AW, 8, LUT address width (<= ACC_W); LUT holds one full sine period, 2^LUT_AW entries
LUT_LAT, 1, LUT read latency in cycles (>= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
enable  in  1  1 = accumulator advances each cycle; 0 = phase holds
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  high when no configuration is pending
cfg_mode  in  3  0 SINE, 1 TRIANGLE, 2 SAW, 3 SQUARE, 4 PWM, 5-7 invalid
cfg_fword  in  ACC_W  phase increment per cycle; f_out = f_clk*fword/2^ACC_W
cfg_duty  in  OUT_W  PWM threshold
cfg_err  out  1  one-cycle pulse when an invalid mode is accepted
lut_addr  out  LUT_AW  sine LUT read address (registered)
lut_data  in  OUT_W  LUT read data, valid LUT_LAT cycles after lut_addr
wave_out  out  OUT_W  output sample (registered)
wave_valid  out  1  pipeline filled, wave_out meaningful
sync_pulse  out  1  one cycle, coincident with the first sample of each new period on wave_out

Behaviour:
- Reset (rst_n=0 at a clk edge): acc=0; active mode=SINE, fword=0, duty=2^(OUT_W-1); pending cleared.
  - Outputs: cfg_ready=1, cfg_err=0, lut_addr=0, wave_out=0, wave_valid=0, sync_pulse=0.
  - Reset mid-pending discards the pending configuration.
- Accumulator: when enable=1, acc <= acc + fword (mod 2^ACC_W). Wrap = carry out of that add. No wrap while enable=0.
- Handshake: transfer when cfg_valid && cfg_ready.
  - A valid mode is latched into the pending register; cfg_ready drops the next cycle.
  - An invalid mode (5-7) is not latched: cfg_err pulses the next cycle, cfg_ready stays 1, and active config is unchanged.
- Apply pending: on the edge where a wrap occurs, the active mode/fword/duty take the pending values and cfg_ready returns to 1 the next cycle.
  - If enable=0 or active fword=0, apply on the first edge after acceptance.
  - acc is not reset on apply; the wrap remainder is kept.
- Pipeline, P = acc value:
  - Stage 1 registers lut_addr = P[ACC_W-1 -: LUT_AW], P[ACC_W-1 -: OUT_W+1] and the mode.
  - Stage 1+LUT_LAT: lut_data is available.
  - Output register: wave_out.
  - Total latency from the acc register to wave_out = LUT_LAT+2 edges, identical for every mode. Computed modes use a matching delay line.
  - The mode travels with its samples, so a mode change appears on wave_out cleanly at one sample boundary.
- Waveforms, with h = P[ACC_W-1], s = P[ACC_W-1 -: OUT_W], t = P[ACC_W-2 -: OUT_W], MAX = 2^OUT_W-1:
  - SINE: lut_data.
  - TRIANGLE: h=0 -> t; h=1 -> ~t.
  - SAW: s.
  - SQUARE: h=0 -> MAX, else 0.
  - PWM: s < duty -> MAX, else 0. duty=0 gives constant 0; duty=MAX gives low for 1/2^OUT_W of the period.
- wave_valid rises LUT_LAT+2 edges after reset release and stays high until reset; it is unaffected by enable.
- sync_pulse: the wrap flag delayed by LUT_LAT+2; it is also asserted for the very first sample after reset.
- enable=0: acc holds and the pipeline keeps running, so wave_out settles to a steady sample.
- Simultaneous wrap and new cfg handshake on the same edge: the pending register (if any) is applied first; the new offer is refused because cfg_ready=0 that cycle.

Test Plan:
Defaults used: ACC_W=32, OUT_W=8, LUT_AW=8, LUT_LAT=1.
1. Hold rst_n=0 for 3 cycles, then release -> all outputs 0 and cfg_ready=1 during reset; wave_valid=1 exactly 3 edges after release; sync_pulse high on the first valid sample.
2. cfg SAW, fword=0x01000000, enable=1 -> wave_out sequence 0,1,...,255,0 (one step per cycle, 3-cycle lag from acc); sync_pulse every 256 cycles, aligned with wave_out=0.
3. cfg SINE, fword=0x01000000, LUT model returns addr^0x5A with 1-cycle latency -> lut_addr counts 0..255; wave_out = previous lut_addr^0x5A, lagging lut_addr by 2 cycles.
4. Running SAW at fword=0x00800000; offer SQUARE mid-period -> cfg_ready low until the wrap; first SQUARE sample (255) appears on wave_out together with sync_pulse; no partial-period glitch.
5. PWM, duty=64, fword=0x01000000 -> each 256-sample period has exactly 64 samples of 255 then 192 of 0; duty=0 gives all 0; duty=255 gives exactly one 0 per period.
6. Offer mode 5 -> cfg_err single pulse, output unchanged. Offer SQUARE with enable=0 -> applied next edge. Offer TRIANGLE then assert rst_n=0 before the wrap -> after reset the active mode is SINE and the pending config is lost.

Source files
------------

// File: rtl/func_gen_dds.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | func_gen_dds                                                               |
// | DDS waveform generator: phase accumulator, sine LUT and computed waveforms |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module func_gen_dds #(
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int LUT_AW  = 8,
  parameter int LUT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_mode,
  input  logic [ACC_W-1:0]  cfg_fword,
  input  logic [OUT_W-1:0]  cfg_duty,
  output logic              cfg_err,
  output logic [LUT_AW-1:0] lut_addr,
  input  logic [OUT_W-1:0]  lut_data,
  output logic [OUT_W-1:0]  wave_out,
  output logic              wave_valid,
  output logic              sync_pulse
);

  localparam logic [2:0]       c_mode_sine = 3'd0;
  localparam logic [2:0]       c_mode_tri  = 3'd1;
  localparam logic [2:0]       c_mode_saw  = 3'd2;
  localparam logic [2:0]       c_mode_sq   = 3'd3;
  localparam logic [2:0]       c_mode_pwm  = 3'd4;
  localparam logic [OUT_W-1:0] c_max       = {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] c_duty_rst  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam int               c_lat       = LUT_LAT + 2;

  // Accumulator and configuration state
  logic [ACC_W-1:0]  r_acc;
  logic              r_wrap;
  logic [2:0]        r_mode;
  logic [ACC_W-1:0]  r_fword;
  logic [OUT_W-1:0]  r_duty;
  logic              r_pend;
  logic [2:0]        r_pend_mode;
  logic [ACC_W-1:0]  r_pend_fword;
  logic [OUT_W-1:0]  r_pend_duty;
  logic              r_cfg_err;

  logic [ACC_W:0]    w_sum;
  logic              w_wrap;
  logic              w_accept;
  logic              w_mode_ok;
  logic              w_apply;

  assign w_sum     = {1'b0, r_acc} + {1'b0, r_fword};
  assign w_wrap    = enable & w_sum[ACC_W];
  assign w_accept  = cfg_valid & ~r_pend;
  assign w_mode_ok = (cfg_mode <= c_mode_pwm);
  // With no wrap to wait for, a pending config goes live on the next edge.
  assign w_apply   = r_pend & (w_wrap | ~enable | (r_fword == '0));

  assign cfg_ready = ~r_pend;
  assign cfg_err   = r_cfg_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_wrap       <= 1'b1;
      r_mode       <= c_mode_sine;
      r_fword      <= '0;
      r_duty       <= c_duty_rst;
      r_pend       <= 1'b0;
      r_pend_mode  <= c_mode_sine;
      r_pend_fword <= '0;
      r_pend_duty  <= c_duty_rst;
      r_cfg_err    <= 1'b0;
    end else begin
      if (enable) begin
        r_acc <= w_sum[ACC_W-1:0];
      end
      r_wrap    <= w_wrap;
      r_cfg_err <= w_accept & ~w_mode_ok;
      if (w_apply) begin
        r_mode  <= r_pend_mode;
        r_fword <= r_pend_fword;
        r_duty  <= r_pend_duty;
        r_pend  <= 1'b0;
      end else if (w_accept && w_mode_ok) begin
        r_pend       <= 1'b1;
        r_pend_mode  <= cfg_mode;
        r_pend_fword <= cfg_fword;
        r_pend_duty  <= cfg_duty;
      end
    end
  end

  // Sample pipeline: index 0 is stage 1, index LUT_LAT lines up with lut_data
  logic [LUT_AW-1:0] r_lut_addr;
  logic [OUT_W:0]    r_dl_phase [0:LUT_LAT];
  logic [2:0]        r_dl_mode  [0:LUT_LAT];
  logic [OUT_W-1:0]  r_dl_duty  [0:LUT_LAT];
  logic              r_dl_sync  [0:LUT_LAT];
  logic [c_lat-1:0]  r_vld;
  logic [OUT_W-1:0]  r_wave;
  logic              r_sync;

  assign lut_addr   = r_lut_addr;
  assign wave_out   = r_wave;
  assign sync_pulse = r_sync;
  assign wave_valid = r_vld[c_lat-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lut_addr <= '0;
      r_vld      <= '0;
      r_wave     <= '0;
      r_sync     <= 1'b0;
      for (int i = 0; i <= LUT_LAT; i++) begin
        r_dl_phase[i] <= '0;
        r_dl_mode[i]  <= c_mode_sine;
        r_dl_duty[i]  <= c_duty_rst;
        r_dl_sync[i]  <= 1'b0;
      end
    end else begin
      r_lut_addr    <= r_acc[ACC_W-1 -: LUT_AW];
      r_dl_phase[0] <= r_acc[ACC_W-1 -: OUT_W+1];
      r_dl_mode[0]  <= r_mode;
      r_dl_duty[0]  <= r_duty;
      r_dl_sync[0]  <= r_wrap;
      for (int i = 1; i <= LUT_LAT; i++) begin
        r_dl_phase[i] <= r_dl_phase[i-1];
        r_dl_mode[i]  <= r_dl_mode[i-1];
        r_dl_duty[i]  <= r_dl_duty[i-1];
        r_dl_sync[i]  <= r_dl_sync[i-1];
      end
      r_vld  <= {r_vld[c_lat-2:0], 1'b1};
      r_wave <= w_wave;
      r_sync <= r_dl_sync[LUT_LAT];
    end
  end

  logic             w_h;
  logic [OUT_W-1:0] w_s;
  logic [OUT_W-1:0] w_t;
  logic [OUT_W-1:0] w_wave;

  assign w_h = r_dl_phase[LUT_LAT][OUT_W];
  assign w_s = r_dl_phase[LUT_LAT][OUT_W:1];
  assign w_t = r_dl_phase[LUT_LAT][OUT_W-1:0];

  always_comb begin
    w_wave = '0;
    case (r_dl_mode[LUT_LAT])
      c_mode_sine: w_wave = lut_data;
      c_mode_tri:  w_wave = w_h ? ~w_t : w_t;
      c_mode_saw:  w_wave = w_s;
      c_mode_sq:   w_wave = w_h ? '0 : c_max;
      c_mode_pwm:  w_wave = (w_s < r_dl_duty[LUT_LAT]) ? c_max : '0;
      default:     w_wave = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_func_gen_dds.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_func_gen_dds                                                            |
// | Scoreboard bench for func_gen_dds with a 1-cycle XOR-pattern LUT model     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_func_gen_dds;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_mode;
  logic [31:0] cfg_fword;
  logic [7:0]  cfg_duty;
  logic        cfg_err;
  logic [7:0]  lut_addr;
  logic [7:0]  lut_data;
  logic [7:0]  wave_out;
  logic        wave_valid;
  logic        sync_pulse;

  always #5 clk = ~clk;

  func_gen_dds #(.ACC_W(32), .OUT_W(8), .LUT_AW(8), .LUT_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_fword(cfg_fword), .cfg_duty(cfg_duty), .cfg_err(cfg_err),
    .lut_addr(lut_addr), .lut_data(lut_data),
    .wave_out(wave_out), .wave_valid(wave_valid), .sync_pulse(sync_pulse)
  );

  always @(posedge clk) lut_data <= lut_addr ^ 8'h5A;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] w;
    logic       s;
    logic       ca;
    logic [7:0] a;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int w, input bit s, input bit ca, input int a);
    item_t it;
    it.c  = c;
    it.w  = w[7:0];
    it.s  = s;
    it.ca = ca;
    it.a  = a[7:0];
    q.push_back(it);
  endtask

  // Monitor: compares each expected sample at its scheduled cycle
  always @(negedge clk) begin : monitor
    item_t it;
    while (q.size() > 0 && q[0].c < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_sample: item for cycle %0d not compared, now %0d", q[0].c, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].c == cyc) begin
      it = q.pop_front();
      chk("wave_out", {24'd0, wave_out}, {24'd0, it.w});
      chk("sync_pulse", {31'd0, sync_pulse}, {31'd0, it.s});
      chk("wave_valid", {31'd0, wave_valid}, 32'd1);
      if (it.ca) chk("lut_addr", {24'd0, lut_addr}, {24'd0, it.a});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    int g = 0;
    while (cyc < c && g < 20000) begin
      tick();
      g++;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() > 0 && g < 3000) begin
      tick();
      g++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d items left, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic send(input logic [2:0] m, input logic [31:0] f, input logic [7:0] d,
                      output int acc_cyc);
    bit rdy;
    int g = 0;
    cfg_mode  = m;
    cfg_fword = f;
    cfg_duty  = d;
    cfg_valid = 1'b1;
    do begin
      rdy = cfg_ready;
      tick();
      g++;
    end while (!rdy && g < 2000);
    cfg_valid = 1'b0;
    acc_cyc   = cyc;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL cfg_handshake: got no transfer, expected cfg_ready within 2000 cycles");
    end
  endtask

  // First edge after base that is a wrap edge later than the acceptance edge
  function automatic int next_apply(input int base, input int acc_cyc, input int period);
    return base + period * ((acc_cyc - base) / period + 1);
  endfunction

  task automatic check_pending(input int app);
    wait_until(app - 1);
    chk("cfg_ready_pending", {31'd0, cfg_ready}, 32'd0);
    tick();
    chk("cfg_ready_applied", {31'd0, cfg_ready}, 32'd1);
  endtask

  task automatic do_reset(input int n);
    int r;
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("rst_wave_out", {24'd0, wave_out}, 32'd0);
      chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      chk("rst_wave_valid", {31'd0, wave_valid}, 32'd0);
      chk("rst_sync", {31'd0, sync_pulse}, 32'd0);
      chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
      chk("rst_lut_addr", {24'd0, lut_addr}, 32'd0);
    end
    rst_n = 1'b1;
    r = cyc;
    push(r + 3, 8'h5A, 1'b1, 1'b0, 0);
    for (int i = 4; i <= 6; i++) push(r + i, 8'h5A, 1'b0, 1'b0, 0);
    tick();
    tick();
    chk("valid_early", {31'd0, wave_valid}, 32'd0);
    drain();
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int a, base, b2, b3, b4, b5, b6, e, h, j, k0;
    rst_n     = 1'b0;
    enable    = 1'b1;
    cfg_valid = 1'b0;
    cfg_mode  = 3'd0;
    cfg_fword = 32'd0;
    cfg_duty  = 8'd0;

    // Reset and first sample (SINE at phase 0 -> LUT(0)^0x5A)
    do_reset(3);

    // SAW at one LSB step per cycle, applied immediately since fword is 0
    send(3'd2, 32'h0100_0000, 8'd128, a);
    chk("cfg_ready_low", {31'd0, cfg_ready}, 32'd0);
    tick();
    chk("cfg_ready_back", {31'd0, cfg_ready}, 32'd1);
    base = a + 1;
    for (int k = 0; k < 300; k++) push(base + 3 + k, k % 256, (k > 0) && (k % 256 == 0), 1'b0, 0);
    drain();

    // SINE via LUT; mode switches at the next wrap
    send(3'd0, 32'h0100_0000, 8'd128, a);
    b2 = next_apply(base, a, 256);
    push(b2 + 2, 255, 1'b0, 1'b0, 0);
    for (int k = 0; k < 260; k++)
      push(b2 + 3 + k, (k % 256) ^ 8'h5A, (k % 256 == 0), 1'b1, (k + 2) % 256);
    check_pending(b2);
    drain();

    // SAW at half speed, then SQUARE offered mid-period
    send(3'd2, 32'h0080_0000, 8'd128, a);
    base = next_apply(b2, a, 256);
    check_pending(base);
    wait_until(base + 200);
    send(3'd3, 32'h0100_0000, 8'd128, e);
    b3 = next_apply(base, e, 512);
    k0 = e - base + 4;
    for (int k = k0; k < 512; k++) push(base + 3 + k, k / 2, 1'b0, 1'b0, 0);
    for (int k = 0; k < 260; k++)
      push(b3 + 3 + k, (k % 256 < 128) ? 255 : 0, (k % 256 == 0), 1'b0, 0);
    check_pending(b3);
    drain();

    // PWM duty 64, then duty 0, then duty 255
    send(3'd4, 32'h0100_0000, 8'd64, a);
    b4 = next_apply(b3, a, 256);
    for (int k = 0; k < 512; k++)
      push(b4 + 3 + k, (k % 256 < 64) ? 255 : 0, (k % 256 == 0), 1'b0, 0);
    check_pending(b4);
    drain();
    send(3'd4, 32'h0100_0000, 8'd0, a);
    b5 = next_apply(b4, a, 256);
    for (int k = 0; k < 256; k++) push(b5 + 3 + k, 0, (k == 0), 1'b0, 0);
    check_pending(b5);
    drain();
    send(3'd4, 32'h0100_0000, 8'd255, a);
    b6 = next_apply(b5, a, 256);
    for (int k = 0; k < 256; k++) push(b6 + 3 + k, (k == 255) ? 0 : 255, (k == 0), 1'b0, 0);
    check_pending(b6);
    drain();

    // Invalid mode: error pulse, configuration untouched across a period boundary
    wait_until(b6 + 506);
    send(3'd5, 32'h1234_5678, 8'd7, a);
    chk("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
    chk("cfg_ready_invalid", {31'd0, cfg_ready}, 32'd1);
    for (int k = a - b6; k < a - b6 + 12; k++)
      push(b6 + 3 + k, (k % 256 == 255) ? 0 : 255, (k % 256 == 0), 1'b0, 0);
    tick();
    chk("cfg_err_single", {31'd0, cfg_err}, 32'd0);
    drain();

    // enable=0 with phase held at 140/256: SQUARE applies on the next edge
    h = b6 + 256 * ((cyc - b6) / 256 + 1) + 140;
    wait_until(h);
    enable = 1'b0;
    send(3'd3, 32'h0100_0000, 8'd128, a);
    chk("cfg_ready_hold", {31'd0, cfg_ready}, 32'd0);
    push(a + 3, 255, 1'b0, 1'b0, 0);
    for (int i = 4; i <= 8; i++) push(a + i, 0, 1'b0, 1'b0, 0);
    tick();
    chk("cfg_ready_hold_applied", {31'd0, cfg_ready}, 32'd1);
    drain();

    // TRIANGLE left pending, then reset discards it
    enable = 1'b1;
    send(3'd1, 32'h0010_0000, 8'd128, j);
    chk("cfg_ready_tri_pending", {31'd0, cfg_ready}, 32'd0);
    do_reset(2);
    chk("cfg_ready_after_reset", {31'd0, cfg_ready}, 32'd1);

    // TRIANGLE waveform shape
    send(3'd1, 32'h0100_0000, 8'd128, a);
    base = a + 1;
    for (int k = 0; k < 260; k++)
      push(base + 3 + k, (k % 256 < 128) ? ((2 * k) % 256) : (255 - ((2 * k) % 256)),
           (k == 256), 1'b0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
